// File: rtl/red_target_pattern_gen.sv
// Synthetic VGA source: grey raster with a bouncing red box and its ground-truth bounding box.
// Optional macro PATTERN_NOISE_EN adds sparse LFSR-driven red noise pixels outside the box.
module red_target_pattern_gen #(
  parameter int BOX_W        = 40,
  parameter int BOX_H        = 30,
  parameter int BOX_X0       = 300,
  parameter int BOX_Y0       = 225,
  parameter int X_LO         = 16,
  parameter int X_HI         = 623,
  parameter int Y_LO         = 8,
  parameter int Y_HI         = 471,
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 751,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 491,
  parameter int V_TOTAL      = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        target_en,
  input  logic        move_en,
  input  logic [3:0]  step,
  output logic        h_sync,
  output logic        v_sync,
  output logic        DE,
  output logic [9:0]  x_pixel,
  output logic [9:0]  y_pixel,
  output logic [15:0] data,
  output logic        frame_start,
  output logic [9:0]  box_x_min,
  output logic [9:0]  box_x_max,
  output logic [9:0]  box_y_min,
  output logic [9:0]  box_y_max,
  output logic [15:0] frame_cnt
);

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_B    = 10'(H_SYNC_START);
  localparam logic [9:0]  HS_E    = 10'(H_SYNC_END);
  localparam logic [9:0]  VS_B    = 10'(V_SYNC_START);
  localparam logic [9:0]  VS_E    = 10'(V_SYNC_END);
  localparam logic [10:0] XLO     = 11'(X_LO);
  localparam logic [10:0] XHI     = 11'(X_HI);
  localparam logic [10:0] YLO     = 11'(Y_LO);
  localparam logic [10:0] YHI     = 11'(Y_HI);
  localparam logic [10:0] BW_M1   = 11'(BOX_W - 1);
  localparam logic [10:0] BH_M1   = 11'(BOX_H - 1);
  localparam logic [10:0] X_CLAMP = 11'(X_HI - BOX_W + 1);
  localparam logic [10:0] Y_CLAMP = 11'(Y_HI - BOX_H + 1);
  localparam logic [9:0]  X0      = 10'(BOX_X0);
  localparam logic [9:0]  Y0      = 10'(BOX_Y0);
  localparam logic [9:0]  X0_MAX  = 10'(BOX_X0 + BOX_W - 1);
  localparam logic [9:0]  Y0_MAX  = 10'(BOX_Y0 + BOX_H - 1);
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] GREY    = 16'h4208;

  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [9:0]  bx_q, bx_d, bxm_q, bxm_d, by_q, by_d, bym_q, bym_d;
  logic        dx_q, dx_d, dy_q, dy_d, ten_q, ten_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [9:0]  xp_q, xp_d, yp_q, yp_d;
  logic [15:0] data_q, data_d;
  logic        active, in_box, noise;
  logic [10:0] xs, ys;

  // One bounce step on one axis; returns {new_dir, new_pos}. All math is 11-bit so nothing wraps.
  function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic dir,
                                            input logic [3:0] st, input logic [10:0] lo,
                                            input logic [10:0] hi, input logic [10:0] len_m1,
                                            input logic [10:0] clamp_hi);
    logic [10:0] p, s, r;
    p = {1'b0, pos};
    s = {7'd0, st};
    if (dir) begin
      if (p + len_m1 + s > hi) return {1'b0, clamp_hi[9:0]};
      r = p + s;
      return {1'b1, r[9:0]};
    end
    if (p < lo + s) return {1'b1, lo[9:0]};
    r = p - s;
    return {1'b0, r[9:0]};
  endfunction

`ifdef PATTERN_NOISE_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end
  assign noise = (lfsr_q[13:0] == 14'd0);
`else
  assign noise = 1'b0;
`endif

  always_comb begin
    h_d    = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
    v_d    = v_q;
    if (h_q == H_LAST) v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    bx_d   = bx_q;
    bxm_d  = bxm_q;
    by_d   = by_q;
    bym_d  = bym_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    fcnt_d = fcnt_q;
    xs     = axis_step(bx_q, dx_q, step, XLO, XHI, BW_M1, X_CLAMP);
    ys     = axis_step(by_q, dy_q, step, YLO, YHI, BH_M1, Y_CLAMP);
    // Latch the enable only on the raster wrap so a frame is never half-drawn.
    ten_d  = (h_q == H_LAST && v_q == V_LAST) ? target_en : ten_q;
    if (h_q == 10'd0 && v_q == V_ACT) begin
      fcnt_d = fcnt_q + 16'd1;
      if (move_en && step != 4'd0) begin
        bx_d  = xs[9:0];
        dx_d  = xs[10];
        bxm_d = xs[9:0] + BW_M1[9:0];
        by_d  = ys[9:0];
        dy_d  = ys[10];
        bym_d = ys[9:0] + BH_M1[9:0];
      end
    end

    active = (h_q < H_ACT) && (v_q < V_ACT);
    in_box = ten_q && (h_q >= bx_q) && (h_q <= bxm_q) && (v_q >= by_q) && (v_q <= bym_q);
    hs_d   = !((h_q >= HS_B) && (h_q <= HS_E));
    vs_d   = !((v_q >= VS_B) && (v_q <= VS_E));
    de_d   = active;
    xp_d   = active ? h_q : 10'd0;
    yp_d   = active ? v_q : 10'd0;
    fs_d   = (h_q == 10'd0) && (v_q == 10'd0);
    data_d = !active ? 16'h0000 : ((in_box || noise) ? RED : GREY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q    <= '0;
      v_q    <= '0;
      bx_q   <= X0;
      bxm_q  <= X0_MAX;
      by_q   <= Y0;
      bym_q  <= Y0_MAX;
      dx_q   <= 1'b1;
      dy_q   <= 1'b1;
      ten_q  <= 1'b0;
      fcnt_q <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      de_q   <= 1'b0;
      xp_q   <= '0;
      yp_q   <= '0;
      data_q <= '0;
      fs_q   <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      bx_q   <= bx_d;
      bxm_q  <= bxm_d;
      by_q   <= by_d;
      bym_q  <= bym_d;
      dx_q   <= dx_d;
      dy_q   <= dy_d;
      ten_q  <= ten_d;
      fcnt_q <= fcnt_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      xp_q   <= xp_d;
      yp_q   <= yp_d;
      data_q <= data_d;
      fs_q   <= fs_d;
    end
  end

  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign DE          = de_q;
  assign x_pixel     = xp_q;
  assign y_pixel     = yp_q;
  assign data        = data_q;
  assign frame_start = fs_q;
  assign box_x_min   = bx_q;
  assign box_x_max   = bxm_q;
  assign box_y_min   = by_q;
  assign box_y_max   = bym_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_red_target_pattern_gen.sv
// Bench for red_target_pattern_gen on a shrunken raster so many frames fit in a short run.
module tb_red_target_pattern_gen;

  localparam int HA = 64, HSS = 68, HSE = 75, HT = 80;
  localparam int VA = 48, VSS = 50, VSE = 51, VT = 54;
  localparam int BW = 8, BH = 6, BX0 = 30, BY0 = 20, XLO = 2, XHI = 61, YLO = 1, YHI = 46;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0, reset = 1'b0, target_en = 1'b0, move_en = 1'b0;
  logic [3:0]  step = 4'd0;
  logic        h_sync, v_sync, DE, frame_start;
  logic [9:0]  x_pixel, y_pixel, box_x_min, box_x_max, box_y_min, box_y_max;
  logic [15:0] data, frame_cnt;

  red_target_pattern_gen #(
    .BOX_W(BW), .BOX_H(BH), .BOX_X0(BX0), .BOX_Y0(BY0),
    .X_LO(XLO), .X_HI(XHI), .Y_LO(YLO), .Y_HI(YHI),
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .reset(reset), .target_en(target_en), .move_en(move_en), .step(step),
    .h_sync(h_sync), .v_sync(v_sync), .DE(DE), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .data(data), .frame_start(frame_start),
    .box_x_min(box_x_min), .box_x_max(box_x_max), .box_y_min(box_y_min), .box_y_max(box_y_max),
    .frame_cnt(frame_cnt)
  );

  always #20 clk = ~clk;

  int errors = 0, checks = 0;
  int red_cnt, de_cnt;

  // Reference: raster position, box geometry and direction, latched enable, frame count.
  int mh, mv, bx, by, fcnt;
  bit dx, dy, ten_q;
  logic [15:0] mlfsr;
  bit e_hs, e_vs, e_de, e_fs;
  int e_x, e_y, e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; bx = BX0; by = BY0; dx = 1; dy = 1; ten_q = 0; fcnt = 0;
    mlfsr = 16'hACE1;
    e_hs = 1; e_vs = 1; e_de = 0; e_x = 0; e_y = 0; e_data = 0; e_fs = 0;
  endtask

  task automatic model_step();
    bit inbox, noise;
    int s;
    e_de  = (mh < HA) && (mv < VA);
    e_x   = e_de ? mh : 0;
    e_y   = e_de ? mv : 0;
    inbox = ten_q && mh >= bx && mh <= bx + BW - 1 && mv >= by && mv <= by + BH - 1;
`ifdef PATTERN_NOISE_EN
    noise = (mlfsr[13:0] == 14'd0);
    mlfsr = {1'b0, mlfsr[15:1]} ^ (mlfsr[0] ? 16'hB400 : 16'h0000);
`else
    noise = 0;
`endif
    e_data = !e_de ? 0 : ((inbox || noise) ? 32'hF800 : 32'h4208);
    e_hs   = !(mh >= HSS && mh <= HSE);
    e_vs   = !(mv >= VSS && mv <= VSE);
    e_fs   = (mh == 0 && mv == 0);
    if (mh == 0 && mv == VA) begin
      fcnt = (fcnt + 1) % 65536;
      s = int'(step);
      if (move_en && s != 0) begin
        if (dx) begin
          if (bx + BW - 1 + s > XHI) begin bx = XHI - BW + 1; dx = 0; end
          else bx = bx + s;
        end else begin
          if (bx < XLO + s) begin bx = XLO; dx = 1; end
          else bx = bx - s;
        end
        if (dy) begin
          if (by + BH - 1 + s > YHI) begin by = YHI - BH + 1; dy = 0; end
          else by = by + s;
        end else begin
          if (by < YLO + s) begin by = YLO; dy = 1; end
          else by = by - s;
        end
      end
    end
    if (mh == HT - 1 && mv == VT - 1) ten_q = target_en;
    mh++;
    if (mh == HT) begin mh = 0; mv = (mv + 1) % VT; end
  endtask

  task automatic check_outputs();
    chk("h_sync", h_sync, e_hs);
    chk("v_sync", v_sync, e_vs);
    chk("DE", DE, e_de);
    chk("x_pixel", x_pixel, e_x);
    chk("y_pixel", y_pixel, e_y);
    chk("data", data, e_data);
    chk("frame_start", frame_start, e_fs);
    chk("box_x_min", box_x_min, bx);
    chk("box_x_max", box_x_max, bx + BW - 1);
    chk("box_y_min", box_y_min, by);
    chk("box_y_max", box_y_max, by + BH - 1);
    chk("frame_cnt", frame_cnt, fcnt);
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
      if (DE === 1'b1) de_cnt++;
      if (DE === 1'b1 && data === 16'hF800) red_cnt++;
      if (rnd && $urandom_range(0, 399) == 0) begin
        target_en = 1'($urandom);
        move_en   = 1'($urandom);
        step      = 4'($urandom);
      end
    end
  endtask

  initial begin
    model_reset();
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_outputs();

    // Static box: frame 0 has no box yet, frame 1 is the first full boxed frame.
    target_en = 1'b1; move_en = 1'b0; step = 4'd0;
    reset = 1'b0;
    run(FRAME, 0);
    red_cnt = 0; de_cnt = 0;
    run(FRAME, 0);
    chk("red_frame1", red_cnt, BW * BH);
    chk("de_frame1", de_cnt, HA * VA);
    chk("box_static", box_x_min, BX0);

    // First motion step of 8 on both axes.
    move_en = 1'b1; step = 4'd8;
    run(FRAME, 0);
    chk("box_x_step", box_x_min, BX0 + 8);
    chk("box_y_step", box_y_min, BY0 + 8);
    chk("frame_cnt3", frame_cnt, 3);

    // Drop target_en at line 10: this frame keeps the box, the next has none.
    red_cnt = 0;
    run(10 * HT, 0);
    target_en = 1'b0;
    run(FRAME - 10 * HT, 0);
    chk("red_after_drop_cur", red_cnt, BW * BH);
    red_cnt = 0;
    run(FRAME, 0);
`ifndef PATTERN_NOISE_EN
    chk("red_after_drop_next", red_cnt, 0);
`endif

    // Randomised enables and steps, including clamp/flip at the window edges.
    target_en = 1'b1; move_en = 1'b1; step = 4'($urandom_range(1, 15));
    run(5 * FRAME, 1);

    // Asynchronous reset mid-frame.
    target_en = 1'b1; move_en = 1'b0; step = 4'd0;
    run(20 * HT + 30, 0);
    #5 reset = 1'b1;
    #1 model_reset();
    check_outputs();
    @(posedge clk);
    #1 check_outputs();
    reset = 1'b0;
    run(2 * FRAME, 0);
    chk("box_after_reset", box_x_min, BX0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
